// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream video test-pattern source: 24-bit {R,G,B} pixels, tuser on the
// first pixel of each frame, tlast on the last pixel of each line, and
// programmable idle gaps after each line and each frame.
module axis_video_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int H_GAP    = 16,
   parameter int V_GAP    = 64
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic [23:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   output logic        m_axis_tuser,
   input  logic        m_axis_tready,
   output logic [7:0]  frame_cnt,
   output logic        frame_done,
   output logic        busy
);

   localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam int BW   = H_ACTIVE / 8;
   localparam int BWW  = (BW > 1) ? $clog2(BW) : 1;
   localparam int GMAX = (H_GAP > V_GAP) ? H_GAP : V_GAP;
   localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

   localparam logic [XW-1:0]  X_LAST  = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0]  Y_LAST  = YW'(V_ACTIVE - 1);
   localparam logic [BWW-1:0] BW_LAST = BWW'(BW - 1);
   localparam logic [GW-1:0]  HG_LAST = GW'((H_GAP > 0) ? H_GAP - 1 : 0);
   localparam logic [GW-1:0]  VG_LAST = GW'((V_GAP > 0) ? V_GAP - 1 : 0);
   localparam logic [XW-1:0]  X_ONE   = XW'(1);
   localparam logic [YW-1:0]  Y_ONE   = YW'(1);
   localparam logic [BWW-1:0] BW_ONE  = BWW'(1);
   localparam logic [GW-1:0]  G_ONE   = GW'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACTIVE    = 2'd1,
      LINE_GAP  = 2'd2,
      FRAME_GAP = 2'd3
   } state_t;

   state_t         state_r, state_s;
   logic [XW-1:0]  x_r, x_s, ldx_s;
   logic [YW-1:0]  y_r, y_s, ldy_s;
   logic [2:0]     bar_r, bar_s, ldbar_s;
   logic [BWW-1:0] bw_r, bw_s, ldbw_s;
   logic [GW-1:0]  gap_r, gap_s;
   logic [1:0]     pat_r, pat_s, ldpat_s;
   logic [7:0]     fcnt_r, fcnt_s, ldfc_s;
   logic [23:0]    tdata_r, data_s;
   logic           tvalid_r, valid_s;
   logic           tlast_r, last_s;
   logic           tuser_r, user_s;
   logic           done_r, done_s;
   logic           busy_r;
   logic           ld_s;

   // Pixel colour for coordinate (px,py); bar is the colour-bar index tracked
   // by the bar-width counter so no divider is needed.
   function automatic logic [23:0] pixel_value(input logic [1:0] pat, input logic [XW-1:0] px,
                                               input logic [YW-1:0] py, input logic [2:0] bar,
                                               input logic [7:0] fc);
      logic [7:0]  x8, y8, r8, g8;
      logic [23:0] res;
      x8 = 8'(px);
      y8 = 8'(py);
      r8 = x8 + fc;
      g8 = y8 + fc;
      case (pat)
         2'd0: begin
            case (bar)
               3'd0:    res = 24'hFFFFFF;
               3'd1:    res = 24'hFFFF00;
               3'd2:    res = 24'h00FFFF;
               3'd3:    res = 24'h00FF00;
               3'd4:    res = 24'hFF00FF;
               3'd5:    res = 24'hFF0000;
               3'd6:    res = 24'h0000FF;
               default: res = 24'h000000;
            endcase
         end
         2'd1:    res = {x8, x8, x8};
         2'd2:    res = (x8[4] ^ y8[4]) ? 24'hFFFFFF : 24'h000000;
         2'd3:    res = {r8, g8, fc};
         default: res = 24'h000000;
      endcase
      return res;
   endfunction

   // Next-state and next-pixel decode; a "load" describes the pixel to present next.
   always_comb begin
      state_s = state_r;
      gap_s   = gap_r;
      fcnt_s  = fcnt_r;
      done_s  = 1'b0;
      valid_s = tvalid_r;
      last_s  = tlast_r;
      user_s  = tuser_r;
      data_s  = tdata_r;
      x_s     = x_r;
      y_s     = y_r;
      bar_s   = bar_r;
      bw_s    = bw_r;
      pat_s   = pat_r;
      ld_s    = 1'b0;
      ldx_s   = {XW{1'b0}};
      ldy_s   = {YW{1'b0}};
      ldbar_s = 3'd0;
      ldbw_s  = {BWW{1'b0}};
      ldpat_s = pat_r;
      ldfc_s  = fcnt_r;
      case (state_r)
         IDLE: begin
            if (enable) begin
               ld_s    = 1'b1;
               ldpat_s = pattern_sel;
               state_s = ACTIVE;
            end else begin
               state_s = IDLE;
            end
         end
         ACTIVE: begin
            if (tvalid_r && m_axis_tready) begin
               if (x_r != X_LAST) begin
                  ld_s  = 1'b1;
                  ldx_s = x_r + X_ONE;
                  ldy_s = y_r;
                  if (bw_r == BW_LAST) begin
                     ldbar_s = bar_r + 3'd1;
                     ldbw_s  = {BWW{1'b0}};
                  end else begin
                     ldbar_s = bar_r;
                     ldbw_s  = bw_r + BW_ONE;
                  end
               end else if (y_r != Y_LAST) begin
                  if (H_GAP > 0) begin
                     state_s = LINE_GAP;
                     gap_s   = {GW{1'b0}};
                     valid_s = 1'b0;
                     last_s  = 1'b0;
                     user_s  = 1'b0;
                  end else begin
                     ld_s  = 1'b1;
                     ldy_s = y_r + Y_ONE;
                  end
               end else begin
                  done_s = 1'b1;
                  fcnt_s = fcnt_r + 8'd1;
                  if (V_GAP > 0) begin
                     state_s = FRAME_GAP;
                     gap_s   = {GW{1'b0}};
                     valid_s = 1'b0;
                     last_s  = 1'b0;
                     user_s  = 1'b0;
                  end else if (enable) begin
                     ld_s    = 1'b1;
                     ldpat_s = pattern_sel;
                     ldfc_s  = fcnt_s;
                  end else begin
                     state_s = IDLE;
                     valid_s = 1'b0;
                     last_s  = 1'b0;
                     user_s  = 1'b0;
                  end
               end
            end else begin
               state_s = ACTIVE;
            end
         end
         LINE_GAP: begin
            if (gap_r == HG_LAST) begin
               ld_s    = 1'b1;
               ldy_s   = y_r + Y_ONE;
               state_s = ACTIVE;
            end else begin
               gap_s = gap_r + G_ONE;
            end
         end
         FRAME_GAP: begin
            if (gap_r == VG_LAST) begin
               if (enable) begin
                  ld_s    = 1'b1;
                  ldpat_s = pattern_sel;
                  state_s = ACTIVE;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               gap_s = gap_r + G_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            valid_s = 1'b0;
         end
      endcase
      if (ld_s) begin
         x_s     = ldx_s;
         y_s     = ldy_s;
         bar_s   = ldbar_s;
         bw_s    = ldbw_s;
         pat_s   = ldpat_s;
         data_s  = pixel_value(ldpat_s, ldx_s, ldy_s, ldbar_s, ldfc_s);
         last_s  = (ldx_s == X_LAST);
         user_s  = (ldx_s == {XW{1'b0}}) && (ldy_s == {YW{1'b0}});
         valid_s = 1'b1;
      end else begin
         data_s = tdata_r;
      end
   end

   // FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath registers: counters, latched pattern and the registered stream outputs.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x_r      <= {XW{1'b0}};
         y_r      <= {YW{1'b0}};
         bar_r    <= 3'd0;
         bw_r     <= {BWW{1'b0}};
         gap_r    <= {GW{1'b0}};
         pat_r    <= 2'd0;
         fcnt_r   <= 8'd0;
         tdata_r  <= 24'd0;
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
         tuser_r  <= 1'b0;
         done_r   <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         x_r      <= x_s;
         y_r      <= y_s;
         bar_r    <= bar_s;
         bw_r     <= bw_s;
         gap_r    <= gap_s;
         pat_r    <= pat_s;
         fcnt_r   <= fcnt_s;
         tdata_r  <= data_s;
         tvalid_r <= valid_s;
         tlast_r  <= last_s;
         tuser_r  <= user_s;
         done_r   <= done_s;
         busy_r   <= (state_s != IDLE);
      end
   end

   assign m_axis_tdata  = tdata_r;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tlast  = tlast_r;
   assign m_axis_tuser  = tuser_r;
   assign frame_cnt     = fcnt_r;
   assign frame_done    = done_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Self-checking bench for axis_video_pattern_gen: expected pixels are queued
// per frame from a reference model and popped on every accepted beat.
module tb_axis_video_pattern_gen;

   localparam int H  = 16;
   localparam int V  = 4;
   localparam int HG = 2;
   localparam int VG = 5;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        enable;
   logic [1:0]  pattern_sel;
   logic [23:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tuser;
   logic        m_axis_tready;
   logic [7:0]  frame_cnt;
   logic        frame_done;
   logic        busy;

   axis_video_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .H_GAP(HG), .V_GAP(VG)) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable), .pattern_sel(pattern_sel),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready), .frame_cnt(frame_cnt),
      .frame_done(frame_done), .busy(busy)
   );

   always #5 aclk = ~aclk;

   int          n_asserts = 0;
   int          n_fail    = 0;
   logic [26:0] sb[$];          // {end_of_frame, tlast, tuser, tdata}
   int          n_beats = 0;
   int          n_done  = 0;
   int          n_tlast = 0;
   int          fidx    = 0;
   logic [23:0] cap17   = 24'd0;
   logic        last_user = 1'b0;

   logic        prev_stall = 1'b0;
   logic [25:0] held       = 26'd0;
   logic        pend_done  = 1'b0;
   logic [7:0]  exp_fc     = 8'd0;
   logic        in_gap     = 1'b0;
   int          gap_run    = 0;
   logic [26:0] e;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] model_pix(input int pat, input int x, input int y, input int fc);
      logic [23:0] r;
      case (pat)
         0: begin
            case (x / (H / 8))
               0: r = 24'hFFFFFF;
               1: r = 24'hFFFF00;
               2: r = 24'h00FFFF;
               3: r = 24'h00FF00;
               4: r = 24'hFF00FF;
               5: r = 24'hFF0000;
               6: r = 24'h0000FF;
               default: r = 24'h000000;
            endcase
         end
         1: r = {8'(x), 8'(x), 8'(x)};
         2: r = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         default: r = {8'(x + fc), 8'(y + fc), 8'(fc)};
      endcase
      return r;
   endfunction

   task automatic push_frame(input int pat, input int fc);
      for (int y = 0; y < V; y++) begin
         for (int x = 0; x < H; x++) begin
            sb.push_back({(x == H - 1 && y == V - 1) ? 1'b1 : 1'b0, (x == H - 1) ? 1'b1 : 1'b0,
                          (x == 0 && y == 0) ? 1'b1 : 1'b0, model_pix(pat, x, y, fc)});
         end
      end
   endtask

   task automatic wait_beats(input int target);
      int t;
      t = 0;
      while (n_beats < target && t < 5000) begin
         @(posedge aclk); #1;
         t++;
      end
      chk("beat_wait_timeout", (n_beats >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int t;
      t = 0;
      @(posedge aclk); #1;
      while ((busy || sb.size() != 0) && t < budget) begin
         @(posedge aclk); #1;
         t++;
      end
      chk("idle_wait_timeout", (!busy && sb.size() == 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   // Monitor: scoreboard pop, hold-under-backpressure, gap lengths, frame_done/frame_cnt.
   always @(negedge aclk) begin
      if (!aresetn) begin
         prev_stall = 1'b0;
         pend_done  = 1'b0;
         exp_fc     = 8'd0;
         in_gap     = 1'b0;
         gap_run    = 0;
      end else begin
         if (pend_done) exp_fc = exp_fc + 8'd1;
         chk("frame_done", {31'd0, frame_done}, {31'd0, pend_done});
         chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_fc});
         pend_done = 1'b0;
         if (frame_done) n_done++;
         if (prev_stall)
            chk("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, {1'b1, held});
         if (in_gap) begin
            if (m_axis_tvalid) begin
               if (m_axis_tuser) chk("frame_gap", gap_run, VG);
               else chk("line_gap", gap_run, HG);
               in_gap = 1'b0;
            end else if (!busy) begin
               in_gap = 1'b0;
            end else begin
               gap_run++;
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            n_beats++;
            chk("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("pixel", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, e[25:0]);
               pend_done = e[26];
            end
            if (m_axis_tlast) begin
               n_tlast++;
               in_gap  = 1'b1;
               gap_run = 0;
            end
            if (m_axis_tuser) fidx = 0;
            else fidx++;
            if (fidx == 17) cap17 = m_axis_tdata;
            last_user = m_axis_tuser;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         held = {m_axis_tlast, m_axis_tuser, m_axis_tdata};
      end
   end

   initial begin
      int base, d0, tl0, t;
      aresetn = 1'b0;
      enable = 1'b0;
      m_axis_tready = 1'b1;
      pattern_sel = 2'd0;
      #3;
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_tuser", m_axis_tuser, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_busy", busy, 0);
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;

      // Colour bars, full throughput, two frames then stop.
      push_frame(0, 0);
      push_frame(0, 1);
      base = n_beats; d0 = n_done;
      enable = 1'b1;
      wait_beats(base + 72);
      enable = 1'b0;
      wait_idle(2000);
      chk("bars_done_count", n_done - d0, 2);
      chk("bars_beats", n_beats - base, 128);
      chk("bars_frame_cnt", frame_cnt, 2);

      // Moving ramp, pattern_sel switched mid-frame to checkerboard.
      push_frame(3, 2);
      push_frame(2, 3);
      pattern_sel = 2'd3;
      base = n_beats;
      enable = 1'b1;
      wait_beats(base + 18);
      chk("ramp_x1y1", cap17, 24'h030302);
      wait_beats(base + 30);
      pattern_sel = 2'd2;
      wait_beats(base + 72);
      enable = 1'b0;
      wait_idle(2000);
      chk("patchg_frame_cnt", frame_cnt, 4);

      // Gradient under random backpressure.
      push_frame(1, 4);
      push_frame(1, 5);
      pattern_sel = 2'd1;
      tl0 = n_tlast; base = n_beats;
      enable = 1'b1;
      t = 0;
      while (t < 3000 && !(n_beats >= base + 128 && !busy)) begin
         @(posedge aclk); #1;
         m_axis_tready = 1'($urandom_range(0, 1));
         if (n_beats >= base + 70) enable = 1'b0;
         t++;
      end
      m_axis_tready = 1'b1;
      wait_idle(2000);
      chk("bp_tlast_count", n_tlast - tl0, 8);
      chk("bp_beats", n_beats - base, 128);
      chk("bp_frame_cnt", frame_cnt, 6);

      // Stop requested at pixel 20: frame completes, frame gap, then idle.
      push_frame(2, 6);
      pattern_sel = 2'd2;
      base = n_beats; d0 = n_done;
      enable = 1'b1;
      wait_beats(base + 20);
      enable = 1'b0;
      t = 0;
      while (!frame_done && t < 500) begin
         @(negedge aclk);
         t++;
      end
      chk("stop_done_seen", frame_done, 1);
      chk("stop_busy_gap0", busy, 1);
      chk("stop_beats", n_beats - base, 64);
      for (int i = 0; i < 4; i++) begin
         @(negedge aclk);
         chk("stop_busy_gap", busy, 1);
         chk("stop_tvalid_gap", m_axis_tvalid, 0);
      end
      @(negedge aclk);
      chk("stop_busy_idle", busy, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge aclk);
         chk("stop_no_tvalid", m_axis_tvalid, 0);
      end
      chk("stop_frame_cnt", frame_cnt, 7);
      chk("stop_sb_empty", sb.size(), 0);
      @(posedge aclk); #1;

      // Asynchronous reset at pixel 37.
      push_frame(0, 7);
      pattern_sel = 2'd0;
      base = n_beats; d0 = n_done;
      enable = 1'b1;
      wait_beats(base + 37);
      #1 aresetn = 1'b0;
      #1;
      chk("arst_tvalid", m_axis_tvalid, 0);
      chk("arst_frame_cnt", frame_cnt, 0);
      chk("arst_frame_done", frame_done, 0);
      chk("arst_busy", busy, 0);
      sb.delete();
      push_frame(0, 0);
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      chk("arst_no_done", n_done - d0, 0);
      base = n_beats;
      wait_beats(base + 1);
      chk("arst_first_tuser", last_user, 1);
      wait_beats(base + 10);
      enable = 1'b0;
      wait_idle(2000);
      chk("arst_frame_cnt_after", frame_cnt, 1);

      // 256 frames of moving ramp: frame_cnt wraps to 0.
      aresetn = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      for (int f = 0; f < 256; f++) push_frame(3, f);
      pattern_sel = 2'd3;
      base = n_beats; d0 = n_done;
      enable = 1'b1;
      t = 0;
      while (n_done < d0 + 255 && t < 25000) begin
         @(posedge aclk); #1;
         t++;
      end
      t = 0;
      while (!m_axis_tvalid && t < 100) begin
         @(posedge aclk); #1;
         t++;
      end
      chk("wrap_last_frame_started", m_axis_tvalid, 1);
      enable = 1'b0;
      wait_idle(3000);
      chk("wrap_done_count", n_done - d0, 256);
      chk("wrap_beats", n_beats - base, 256 * 64);
      chk("wrap_frame_cnt", frame_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
